// File: rtl/sev_seg_pkg.sv
// Shared types and glyph constants for the seven-segment scanner.
// Segment vectors are {g,f,e,d,c,b,a}, active-high internally.
package sev_seg_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_SHOW = 1'b1
  } slot_state_t;

  localparam seg_t SEG_OFF = 7'h00;

  localparam seg_t GLYPH_0 = 7'h3F;
  localparam seg_t GLYPH_1 = 7'h06;
  localparam seg_t GLYPH_2 = 7'h5B;
  localparam seg_t GLYPH_3 = 7'h4F;
  localparam seg_t GLYPH_4 = 7'h66;
  localparam seg_t GLYPH_5 = 7'h6D;
  localparam seg_t GLYPH_6 = 7'h7D;
  localparam seg_t GLYPH_7 = 7'h07;
  localparam seg_t GLYPH_8 = 7'h7F;
  localparam seg_t GLYPH_9 = 7'h6F;
  localparam seg_t GLYPH_A = 7'h77;
  localparam seg_t GLYPH_B = 7'h7C;
  localparam seg_t GLYPH_C = 7'h39;
  localparam seg_t GLYPH_D = 7'h5E;
  localparam seg_t GLYPH_E = 7'h79;
  localparam seg_t GLYPH_F = 7'h71;

endpackage

// File: rtl/sev_seg_hex_decoder.sv
// Pure combinational hex nibble to active-high seven-segment glyph.
module sev_seg_hex_decoder
  import sev_seg_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg_c
);

  always_comb begin
    seg_c = SEG_OFF;
    case (hex)
      4'h0: seg_c = GLYPH_0;
      4'h1: seg_c = GLYPH_1;
      4'h2: seg_c = GLYPH_2;
      4'h3: seg_c = GLYPH_3;
      4'h4: seg_c = GLYPH_4;
      4'h5: seg_c = GLYPH_5;
      4'h6: seg_c = GLYPH_6;
      4'h7: seg_c = GLYPH_7;
      4'h8: seg_c = GLYPH_8;
      4'h9: seg_c = GLYPH_9;
      4'hA: seg_c = GLYPH_A;
      4'hB: seg_c = GLYPH_B;
      4'hC: seg_c = GLYPH_C;
      4'hD: seg_c = GLYPH_D;
      4'hE: seg_c = GLYPH_E;
      4'hF: seg_c = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Multiplexed N-digit seven-segment scanner with prescaler, dead time,
// frame-synchronous capture, leading-zero suppression and pin polarity.
module sev_seg_scan_ctrl
  import sev_seg_pkg::*;
#(
  parameter  int unsigned NUM_DIGITS  = 4,
  parameter  int unsigned DIV_WIDTH   = 16,
  parameter  int unsigned DEAD_CYCLES = 2,
  parameter  bit          ACTIVE_LOW  = 1'b1,
  localparam int unsigned IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DIV_WIDTH-1:0]    div_period,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    update,
  input  logic                    lz_suppress,
  input  logic                    blank_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [IDX_W-1:0]        scan_idx,
  output logic                    frame_start
);

  localparam int unsigned     DEAD_W   = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam seg_t            POL_SEG  = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] POL_AN = {NUM_DIGITS{ACTIVE_LOW}};

  logic [DIV_WIDTH-1:0]             cnt;
  logic [DIV_WIDTH-1:0]             period_m1;
  logic                             tick;
  logic                             wrap;
  logic                             capture;
  logic                             pending;
  logic [NUM_DIGITS-1:0][3:0]       shadow_digit;
  logic [NUM_DIGITS-1:0]            shadow_dp;
  slot_state_t                      state, state_nxt;
  logic [DEAD_W-1:0]                dead_cnt, dead_nxt;
  logic [NUM_DIGITS-1:0]            lz_blank;
  logic                             zero_above;
  logic [3:0]                       cur_digit;
  seg_t                             dec_seg;
  logic                             lit;
  logic [NUM_DIGITS-1:0]            an_nxt;
  seg_t                             seg_nxt;
  logic                             dp_nxt;

  // Prescaler: a zero period behaves as one; a shrunk period ticks at once.
  always_comb begin
    period_m1 = '0;
    if (div_period != '0) period_m1 = div_period - DIV_WIDTH'(1);
  end

  assign tick    = (cnt >= period_m1);
  assign wrap    = tick && (scan_idx == LAST_IDX);
  assign capture = wrap && (pending || update);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= tick ? '0 : cnt + DIV_WIDTH'(1);
  end

  // Slot index and frame marker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_idx    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (tick) scan_idx <= wrap ? '0 : scan_idx + IDX_W'(1);
    end
  end

  // Shadow copy only changes on the wrapping tick, so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_digit <= '0;
      shadow_dp    <= '0;
      pending      <= 1'b0;
    end else if (capture) begin
      shadow_digit <= digits_in;
      shadow_dp    <= dp_in;
      pending      <= 1'b0;
    end else if (update) begin
      pending      <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_DEAD;
      dead_cnt <= DEAD_W'(DEAD_CYCLES);
    end else begin
      state    <= state_nxt;
      dead_cnt <= dead_nxt;
    end
  end

  // Every slot opens dark for DEAD_CYCLES; a tick always restarts the slot.
  always_comb begin
    state_nxt = state;
    dead_nxt  = dead_cnt;
    if (tick) begin
      dead_nxt  = DEAD_W'(DEAD_CYCLES);
      state_nxt = (DEAD_CYCLES == 0) ? ST_SHOW : ST_DEAD;
    end else begin
      case (state)
        ST_DEAD: begin
          if (dead_cnt <= DEAD_W'(1)) begin
            dead_nxt  = '0;
            state_nxt = ST_SHOW;
          end else begin
            dead_nxt  = dead_cnt - DEAD_W'(1);
          end
        end
        ST_SHOW: state_nxt = ST_SHOW;
        default: state_nxt = ST_DEAD;
      endcase
    end
  end

  // A digit blanks when it and everything to its left are zero without a dp.
  always_comb begin
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_blank[k] = lz_suppress && zero_above && (shadow_digit[k] == 4'h0);
      zero_above  = zero_above && (shadow_digit[k] == 4'h0) && !shadow_dp[k];
    end
  end

  assign cur_digit = shadow_digit[scan_idx];

  sev_seg_hex_decoder u_decoder (
    .hex   (cur_digit),
    .seg_c (dec_seg)
  );

  always_comb begin
    lit     = (state == ST_SHOW) && !blank_in;
    an_nxt  = '0;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b0;
    if (lit) begin
      an_nxt  = NUM_DIGITS'(1) << scan_idx;
      seg_nxt = lz_blank[scan_idx] ? SEG_OFF : dec_seg;
      dp_nxt  = shadow_dp[scan_idx];
    end
  end

  // Pin registers, polarity applied here only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_out  <= POL_AN;
      seg_out <= POL_SEG;
      dp_out  <= ACTIVE_LOW;
    end else begin
      an_out  <= an_nxt ^ POL_AN;
      seg_out <= seg_nxt ^ POL_SEG;
      dp_out  <= dp_nxt ^ ACTIVE_LOW;
    end
  end

endmodule
